uart_rx: RTL and testbench

UART receiver that consumes the one-cycle 16x-oversampling tick produced by the baud generator and recovers serial frames.
- Frame format: start bit, DBIT data bits (LSB first), optional parity bit, stop bit.
- Delivers each received byte with a one-cycle done pulse plus framing and parity error flags.
- Sits between the pad-side rx line and the receive FIFO/host interface.

---
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver. Recovers start/data/[parity]/stop
// frames from the rx line and presents each word with a one-clock done pulse
// plus framing and parity error flags.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | line idle, waiting for rx_s low (no tick needed to leave)
//   START  | counting to mid start bit; high there means glitch -> IDLE
//   DATA   | sampling DBIT data bits LSB first, one every 16 ticks
//   PARITY | sampling the parity bit and latching the mismatch flag
//   STOP   | waiting SB_TICK ticks, then delivering the word
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [4:0] MID_START = 5'd7;
  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam logic       PODD      = (PARITY_ODD != 0);
  localparam bit         PEN       = (PARITY_EN != 0);

  logic [1:0]      sync_q, sync_d;
  logic            rx_s;
  state_t          state_q, state_d;
  logic [4:0]      s_cnt_q, s_cnt_d;
  logic [2:0]      n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            perr_q, perr_d;
  logic [DBIT-1:0] rx_data_q, rx_data_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            perr_out_q, perr_out_d;

  // Two-flop synchronizer for the asynchronous rx line; idle high.
  assign sync_d = {sync_q[0], rx};
  assign rx_s   = sync_q[1];

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      n_cnt_q    <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      n_cnt_q    <= n_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
    end
  end

  // Next-state and datapath updates; counters only advance on s_tick.
  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    n_cnt_d    = n_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    rx_data_d  = rx_data_q;
    ferr_d     = ferr_q;
    perr_out_d = perr_out_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == MID_START) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            shift_d = {rx_s, shift_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) begin
              state_d = PEN ? PARITY : STOP;
            end else begin
              n_cnt_d = n_cnt_q + 3'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            perr_d  = ((^shift_q) ^ rx_s) != PODD;
            state_d = STOP;
            s_cnt_d = '0;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            rx_data_d  = shift_q;
            ferr_d     = ~rx_s;
            perr_out_d = PEN ? perr_q : 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data      = rx_data_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perr_out_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives three receivers (no parity, even parity, odd parity)
// with directed and random frames; expected words come from a frame-level
// model pushed into per-receiver queues.
module tb_uart_rx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s_tick = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] data_o [3];
  logic       done_o [3];
  logic       fe_o   [3];
  logic       pe_o   [3];

  int errors = 0;
  int checks = 0;
  int dvsr   = 4;
  int tcnt   = 0;

  logic [9:0] cap [3][$];
  logic [9:0] exp [3][$];
  logic       prev_done [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .s_tick(s_tick),
    .rx_data(data_o[0]), .rx_done_tick(done_o[0]),
    .frame_err(fe_o[0]), .parity_err(pe_o[0]));
  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .s_tick(s_tick),
    .rx_data(data_o[1]), .rx_done_tick(done_o[1]),
    .frame_err(fe_o[1]), .parity_err(pe_o[1]));
  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .s_tick(s_tick),
    .rx_data(data_o[2]), .rx_done_tick(done_o[2]),
    .frame_err(fe_o[2]), .parity_err(pe_o[2]));

  // Baud tick: one clock high every dvsr clocks (constant high for dvsr=1).
  always @(negedge clk) begin
    if (tcnt >= dvsr - 1) begin
      tcnt   = 0;
      s_tick = 1'b1;
    end else begin
      tcnt   = tcnt + 1;
      s_tick = 1'b0;
    end
  end

  // Capture every done pulse and check it lasts exactly one clock.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_o[k]) begin
        checks++;
        assert (prev_done[k] === 1'b0) else begin
          errors++;
          $error("FAIL pulse_width dut%0d: done high on consecutive clocks, required single-clock pulse", k);
        end
        if (!prev_done[k]) cap[k].push_back({fe_o[k], pe_o[k], data_o[k]});
      end
      prev_done[k] = done_o[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic set_rx(input int k, input logic v);
    case (k)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic drive(input int k, input logic v, input int ticks);
    set_rx(k, v);
    repeat (ticks * dvsr) @(negedge clk);
  endtask

  // Model: word delivered as sent; frame_err = stop bit low; parity_err set
  // when the count of ones over data plus parity bit has the wrong sense.
  task automatic send_frame(input int k, input logic [7:0] d, input logic p, input logic stop);
    int ones;
    logic perr;
    drive(k, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(k, d[i], 16);
    if (k != 0) drive(k, p, 16);
    if (stop) begin
      drive(k, 1'b1, 16);
    end else begin
      drive(k, 1'b0, 10);
      drive(k, 1'b1, 6);
    end
    ones = $countones(d) + int'(p);
    perr = (k == 0) ? 1'b0 : ((ones % 2) != ((k == 2) ? 1 : 0));
    exp[k].push_back({~stop, perr, d});
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_count_dut%0d", tag, k), cap[k].size(), exp[k].size());
      for (int i = 0; i < exp[k].size() && i < cap[k].size(); i++)
        chk($sformatf("%s_word%0d_dut%0d", tag, i, k), {22'd0, cap[k][i]}, {22'd0, exp[k][i]});
      cap[k].delete();
      exp[k].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic abort_then_send(input string tag);
    logic [7:0] d = 8'h5A;
    drive(0, 1'b0, 16);
    for (int i = 0; i < 5; i++) drive(0, d[i], 16);
    drive(0, d[5], 4);
    do_reset();
    chk({tag, "_rst_data"}, data_o[0], 8'h00);
    chk({tag, "_rst_done"}, done_o[0], 1'b0);
    drive(0, 1'b1, 32);
    compare_all({tag, "_abort"});
    send_frame(0, 8'h81, 1'b0, 1'b1);
    drive(0, 1'b1, 32);
    compare_all({tag, "_after"});
    chk({tag, "_hold"}, data_o[0], 8'h81);
  endtask

  initial begin
    logic [7:0] r;
    logic       rp;
    dvsr = 4;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_data_dut%0d", k), data_o[k], 8'h00);
      chk($sformatf("reset_done_dut%0d", k), done_o[k], 1'b0);
      chk($sformatf("reset_ferr_dut%0d", k), fe_o[k], 1'b0);
      chk($sformatf("reset_perr_dut%0d", k), pe_o[k], 1'b0);
    end
    reset = 1'b1;
    repeat (8) @(negedge clk);

    send_frame(0, 8'hA5, 1'b0, 1'b1);
    drive(0, 1'b1, 32);
    compare_all("a5");
    chk("a5_hold", data_o[0], 8'hA5);

    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    drive(0, 1'b1, 32);
    compare_all("b2b");

    drive(0, 1'b0, 3);
    drive(0, 1'b1, 48);
    compare_all("glitch");
    chk("glitch_hold", data_o[0], 8'hFF);

    send_frame(0, 8'h3C, 1'b0, 1'b0);
    drive(0, 1'b1, 32);
    compare_all("ferr");
    chk("ferr_hold", fe_o[0], 1'b1);
    send_frame(0, 8'h55, 1'b0, 1'b1);
    drive(0, 1'b1, 32);
    compare_all("clean");

    for (int k = 1; k < 3; k++) begin
      send_frame(k, 8'h07, 1'b1, 1'b1);
      drive(k, 1'b1, 24);
      send_frame(k, 8'h07, 1'b0, 1'b1);
      drive(k, 1'b1, 24);
    end
    compare_all("par07");

    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 3; k++) begin
        r  = 8'($urandom_range(0, 255));
        rp = 1'($urandom_range(0, 1));
        send_frame(k, r, rp, 1'($urandom_range(0, 3) != 0));
        drive(k, 1'b1, 24);
      end
    end
    compare_all("rand");

    abort_then_send("abort4");
    @(negedge clk);
    dvsr = 1;
    repeat (4) @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      r = 8'($urandom_range(0, 255));
      send_frame(0, r, 1'b0, 1'b1);
    end
    drive(0, 1'b1, 32);
    compare_all("dvsr1_b2b");
    abort_then_send("abort1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
